dbg_apb_master: RTL and testbench



---
 rtl/dbg_apb_master.sv | 146 ++++++++++++++
 tb/tb_dbg_apb_master.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dbg_apb_master.sv
// dbg_apb_master: turns a debug command stream into single APB transfers and returns responses.
// Optional ACCESS-phase timeout abort is enabled by defining DBG_APB_TIMEOUT_EN.
module dbg_apb_master #(
    parameter int unsigned ADDR_WIDTH     = 5,
    parameter int unsigned WDATA_WIDTH    = 32,
    parameter int unsigned RDATA_WIDTH    = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_wr_rd,
    input  logic [ADDR_WIDTH-1:0]  cmd_addr,
    input  logic [WDATA_WIDTH-1:0] cmd_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic                   rsp_wr_rd,
    output logic [RDATA_WIDTH-1:0] rsp_rdata,
    output logic                   rsp_err,
    output logic [ADDR_WIDTH-1:0]  apb_addr,
    output logic                   apb_sel,
    output logic                   apb_enable,
    output logic                   apb_wr_rd,
    output logic [WDATA_WIDTH-1:0] apb_wdata,
    input  logic                   apb_ready,
    input  logic [RDATA_WIDTH-1:0] apb_rdata
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t                 r_state;
    logic                   r_cmd_ready;
    logic                   r_rsp_valid;
    logic                   r_rsp_wr_rd;
    logic [RDATA_WIDTH-1:0] r_rsp_rdata;
    logic                   r_rsp_err;
    logic [ADDR_WIDTH-1:0]  r_apb_addr;
    logic                   r_apb_sel;
    logic                   r_apb_enable;
    logic                   r_apb_wr_rd;
    logic [WDATA_WIDTH-1:0] r_apb_wdata;

`ifdef DBG_APB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] r_to_cnt;
    logic             w_to_hit;
    assign w_to_hit = (r_to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    assign cmd_ready  = r_cmd_ready;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_wr_rd  = r_rsp_wr_rd;
    assign rsp_rdata  = r_rsp_rdata;
    assign rsp_err    = r_rsp_err;
    assign apb_addr   = r_apb_addr;
    assign apb_sel    = r_apb_sel;
    assign apb_enable = r_apb_enable;
    assign apb_wr_rd  = r_apb_wr_rd;
    assign apb_wdata  = r_apb_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cmd_ready  <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_wr_rd  <= 1'b0;
            r_rsp_rdata  <= '0;
            r_rsp_err    <= 1'b0;
            r_apb_addr   <= '0;
            r_apb_sel    <= 1'b0;
            r_apb_enable <= 1'b0;
            r_apb_wr_rd  <= 1'b0;
            r_apb_wdata  <= '0;
`ifdef DBG_APB_TIMEOUT_EN
            r_to_cnt     <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    // cmd_ready is a register, so it rises one cycle after reset release
                    if (r_cmd_ready && cmd_valid) begin
                        r_cmd_ready <= 1'b0;
                        r_apb_addr  <= cmd_addr;
                        r_apb_wr_rd <= cmd_wr_rd;
                        r_apb_wdata <= cmd_wdata;
                        r_apb_sel   <= 1'b1;
                        r_state     <= SETUP;
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end
                SETUP: begin
                    r_apb_enable <= 1'b1;
                    r_state      <= ACCESS;
`ifdef DBG_APB_TIMEOUT_EN
                    r_to_cnt     <= '0;
`endif
                end
                ACCESS: begin
                    if (apb_ready) begin
                        r_apb_sel    <= 1'b0;
                        r_apb_enable <= 1'b0;
                        r_apb_wdata  <= '0;
                        r_rsp_valid  <= 1'b1;
                        r_rsp_wr_rd  <= r_apb_wr_rd;
                        r_rsp_rdata  <= r_apb_wr_rd ? '0 : apb_rdata;
                        r_rsp_err    <= 1'b0;
                        r_state      <= RESP;
`ifdef DBG_APB_TIMEOUT_EN
                    end else if (w_to_hit) begin
                        r_apb_sel    <= 1'b0;
                        r_apb_enable <= 1'b0;
                        r_apb_wdata  <= '0;
                        r_rsp_valid  <= 1'b1;
                        r_rsp_wr_rd  <= r_apb_wr_rd;
                        r_rsp_rdata  <= '0;
                        r_rsp_err    <= 1'b1;
                        r_state      <= RESP;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
`endif
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        assert (TIMEOUT_CYCLES >= 2)
            else $error("dbg_apb_master: TIMEOUT_CYCLES below 2");
        if (rst_n && cmd_valid) begin
            assert (!$isunknown(cmd_addr))
                else $error("dbg_apb_master: X on cmd_addr while cmd_valid high");
        end
    end

endmodule

// File: tb/tb_dbg_apb_master.sv
// Directed + randomized bench for dbg_apb_master with an APB slave memory and a
// reference register model; inputs are driven and outputs sampled on the falling edge.
module tb_dbg_apb_master;

    localparam logic [4:0] ADDR_ITR3 = 5'h0F;  // ITR3 index in the core debug register map

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_wr_rd;
    logic [4:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_wr_rd;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [4:0]  apb_addr;
    logic        apb_sel;
    logic        apb_enable;
    logic        apb_wr_rd;
    logic [31:0] apb_wdata;
    logic        apb_ready;
    logic [31:0] apb_rdata;

    int unsigned n_assert;
    int unsigned n_fail;
    logic [31:0] ref_mem [32];
    logic [31:0] slv_mem [32];

    dbg_apb_master #(
        .ADDR_WIDTH(5),
        .WDATA_WIDTH(32),
        .RDATA_WIDTH(32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_wr_rd(cmd_wr_rd),
        .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_wr_rd(rsp_wr_rd),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .apb_addr(apb_addr),
        .apb_sel(apb_sel),
        .apb_enable(apb_enable),
        .apb_wr_rd(apb_wr_rd),
        .apb_wdata(apb_wdata),
        .apb_ready(apb_ready),
        .apb_rdata(apb_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
            else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", tag, obs, exp);
            end
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
        chk({pfx, "_rsp_flags"}, 32'({rsp_valid, rsp_wr_rd, rsp_err}), 32'd0);
        chk({pfx, "_rsp_rdata"}, rsp_rdata, 32'd0);
        chk({pfx, "_apb_ctl"}, 32'({apb_sel, apb_enable, apb_wr_rd}), 32'd0);
        chk({pfx, "_apb_addr"}, 32'(apb_addr), 32'd0);
        chk({pfx, "_apb_wdata"}, apb_wdata, 32'd0);
    endtask

    // While a transfer is busy, optionally keep offering junk commands that must not be taken
    task automatic cmd_noise(input bit keep_valid);
        if (keep_valid) begin
            cmd_valid = 1'b1;
            cmd_wr_rd = 1'($urandom_range(0, 1));
            cmd_addr  = 5'($urandom_range(0, 31));
            cmd_wdata = $urandom;
        end else begin
            cmd_valid = 1'b0;
        end
    endtask

    // Entered on a falling edge with the DUT idle; leaves one cycle after the response handshake
    task automatic xfer(input logic wr, input logic [4:0] addr, input logic [31:0] wdata,
                        input int unsigned waits, input int unsigned hold, input bit keep_valid);
        logic [31:0] exp_rdata;
        exp_rdata = wr ? 32'd0 : ref_mem[addr];
        if (wr) ref_mem[addr] = wdata;
        chk("pre_cmd_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_wr_rd = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        apb_ready = 1'($urandom_range(0, 1));
        apb_rdata = $urandom;
        @(negedge clk);
        chk("setup_sel", 32'(apb_sel), 32'd1);
        chk("setup_en", 32'(apb_enable), 32'd0);
        chk("setup_addr", 32'(apb_addr), 32'(addr));
        chk("setup_dir", 32'(apb_wr_rd), 32'(wr));
        chk("setup_wdata", apb_wdata, wdata);
        chk("setup_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("setup_rsp_valid", 32'(rsp_valid), 32'd0);
        cmd_noise(keep_valid);
        apb_ready = 1'($urandom_range(0, 1));
        for (int unsigned i = 0; i <= waits; i++) begin
            @(negedge clk);
            chk("access_sel_en", 32'({apb_sel, apb_enable}), 32'd3);
            chk("access_addr", 32'(apb_addr), 32'(addr));
            chk("access_dir", 32'(apb_wr_rd), 32'(wr));
            chk("access_wdata", apb_wdata, wdata);
            chk("access_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("access_cmd_ready", 32'(cmd_ready), 32'd0);
            cmd_noise(keep_valid);
            if (i == waits) begin
                apb_ready = 1'b1;
                if (apb_wr_rd) slv_mem[apb_addr] = apb_wdata;
                else           apb_rdata = slv_mem[apb_addr];
            end else begin
                apb_ready = 1'b0;
                apb_rdata = $urandom;
            end
        end
        @(negedge clk);
        apb_ready = 1'($urandom_range(0, 1));
        apb_rdata = $urandom;
        for (int unsigned h = 0; h <= hold; h++) begin
            chk("resp_valid", 32'(rsp_valid), 32'd1);
            chk("resp_dir", 32'(rsp_wr_rd), 32'(wr));
            chk("resp_rdata", rsp_rdata, exp_rdata);
            chk("resp_err", 32'(rsp_err), 32'd0);
            chk("resp_apb_ctl", 32'({apb_sel, apb_enable}), 32'd0);
            chk("resp_apb_wdata", apb_wdata, 32'd0);
            chk("resp_cmd_ready", 32'(cmd_ready), 32'd0);
            rsp_ready = (h == hold);
            cmd_noise(keep_valid);
            @(negedge clk);
        end
        rsp_ready = 1'b0;
        chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("post_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("post_sel", 32'(apb_sel), 32'd0);
    endtask

    initial begin
        int unsigned seen;
        n_assert  = 0;
        n_fail    = 0;
        seen      = 0;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_wr_rd = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        apb_ready = 1'b0;
        apb_rdata = '0;
        for (int i = 0; i < 32; i++) begin
            ref_mem[i] = $urandom;
            slv_mem[i] = ref_mem[i];
        end

        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_cmd_ready", 32'(cmd_ready), 32'd1);

        // zero-wait write, 3-wait read of the same register, then response backpressure
        xfer(1'b1, 5'h03, 32'hDEADBEEF, 0, 0, 1'b0);
        xfer(1'b0, 5'h03, 32'h0, 3, 0, 1'b0);
        xfer(1'b1, 5'h11, 32'h0BADF00D, 2, 10, 1'b1);
        xfer(1'b0, 5'h11, 32'h0, 1, 0, 1'b0);

        for (int unsigned n = 0; n < 24; n++) begin
            xfer(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                 $urandom_range(0, 4), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        xfer(1'b1, ADDR_ITR3, 32'h00000013, 1, 0, 1'b0);
        xfer(1'b0, ADDR_ITR3, 32'h0, 0, 0, 1'b0);

        // stuck slave: apb_ready never rises
        cmd_valid = 1'b1;
        cmd_wr_rd = 1'b0;
        cmd_addr  = 5'h07;
        apb_ready = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("stuck_setup", 32'({apb_sel, apb_enable}), 32'd2);
`ifdef DBG_APB_TIMEOUT_EN
        for (int unsigned i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("to_access", 32'({apb_sel, apb_enable}), 32'd3);
            chk("to_no_rsp", 32'(rsp_valid), 32'd0);
        end
        @(negedge clk);
        chk("to_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("to_rsp_err", 32'(rsp_err), 32'd1);
        chk("to_rsp_rdata", rsp_rdata, 32'd0);
        chk("to_rsp_dir", 32'(rsp_wr_rd), 32'd0);
        chk("to_apb_ctl", 32'({apb_sel, apb_enable}), 32'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("to_post_valid", 32'(rsp_valid), 32'd0);
        chk("to_post_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_pre_access", 32'({apb_sel, apb_enable}), 32'd3);
`else
        repeat (1000) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk("no_timeout_rsp", seen, 32'd0);
        chk("no_timeout_access", 32'({apb_sel, apb_enable}), 32'd3);
`endif

        // asynchronous reset in the middle of ACCESS
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_rel_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_rel_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rel_sel", 32'(apb_sel), 32'd0);
        xfer(1'b0, ADDR_ITR3, 32'h0, 2, 1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
